// File: rtl/array_mult_pipe.sv
// array_mult_pipe: pipelined carry-save array multiplier with a global valid/ready advance.
// Define ARRAY_MULT_SIGNED_EN for two's complement operands and product (Baugh-Wooley).
module array_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);
    localparam int S = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t             stage_q [S];
    stage_t             stage_d [S];
    logic [S-1:0]       v;
    logic [S:0]         v_in;
    logic               adv;
    logic [2*WIDTH-1:0] p_d;

    function automatic logic pp_bit(stage_t x, int i, int j);
`ifdef ARRAY_MULT_SIGNED_EN
        return (x.a[j] & x.b[i]) ^ ((i == WIDTH-1) != (j == WIDTH-1));
`else
        return x.a[j] & x.b[i];
`endif
    endfunction

    // Rows first..last-1; after each row the sum vector shifts down one weight and its LSB retires into lo.
    function automatic stage_t rows(stage_t x, int first, int last);
        stage_t y;
        logic [WIDTH-1:0] sv;
        logic [WIDTH-1:0] cv;
        logic pp;
        y = x;
        sv = '0;
        cv = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= first && i < last) begin
                for (int j = 0; j < WIDTH; j++) begin
                    pp = pp_bit(y, i, j);
                    sv[j] = pp ^ y.s[j] ^ y.c[j];
                    cv[j] = (pp & y.s[j]) | (pp & y.c[j]) | (y.s[j] & y.c[j]);
                end
                y.lo[i] = sv[0];
                y.s = {1'b0, sv[WIDTH-1:1]};
                y.c = cv;
            end
        end
        return y;
    endfunction

    // Ripple merge of the high half; in signed mode the carry-in and MSB flip add the 2^W and 2^(2W-1) constants.
    function automatic logic [2*WIDTH-1:0] merge(stage_t x);
        logic [WIDTH-1:0] hi;
        logic rc;
`ifdef ARRAY_MULT_SIGNED_EN
        rc = 1'b1;
`else
        rc = 1'b0;
`endif
        hi = '0;
        for (int j = 0; j < WIDTH; j++) begin
            hi[j] = x.s[j] ^ x.c[j] ^ rc;
            rc = (x.s[j] & x.c[j]) | (rc & (x.s[j] ^ x.c[j]));
        end
`ifdef ARRAY_MULT_SIGNED_EN
        return {~hi[WIDTH-1], hi[WIDTH-2:0], x.lo};
`else
        return {hi, x.lo};
`endif
    endfunction

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign v_in     = {v, in_valid};

    assign stage_d[0] = {{(3*WIDTH){1'b0}}, a, b};
    for (genvar k = 1; k < S; k++) begin : g_stage
        assign stage_d[k] = rows(stage_q[k-1], (k-1)*ROWS_PER_STAGE, k*ROWS_PER_STAGE);
    end
    assign p_d = merge(rows(stage_q[S-1], (S-1)*ROWS_PER_STAGE, WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v         <= '0;
            out_valid <= 1'b0;
            p         <= '0;
        end else if (adv) begin
            v         <= v_in[S-1:0];
            out_valid <= v_in[S];
            if (v_in[S]) p <= p_d;
        end
    end

    // Payload registers only load behind a valid token, so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        for (int k = 0; k < S; k++)
            if (adv && v_in[k]) stage_q[k] <= stage_d[k];
    end
endmodule

// File: tb/tb_array_mult_pipe.sv
// tb_array_mult_pipe: scoreboard bench for array_mult_pipe (8-bit/2-row instance plus 4-bit/1-row instance).
module tb_array_mult_pipe;
    localparam int W = 8;
    localparam int R = 2;
    localparam int S = (W + R - 1) / R;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2*W-1:0] p;
    logic in_valid4 = 1'b0;
    logic in_ready4;
    logic out_valid4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic [7:0] p4;

    int vectors = 0;
    int miscompares = 0;
    int q[$];
    int q4[$];
    int cyc = 0;
    int first_acc4 = -1;
    int first_out4 = -1;
    int last_out4 = -1;
    int got4 = 0;

    array_mult_pipe #(.WIDTH(W), .ROWS_PER_STAGE(R)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    array_mult_pipe #(.WIDTH(4), .ROWS_PER_STAGE(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(1'b1), .p(p4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(int x, int y, int w);
`ifdef ARRAY_MULT_SIGNED_EN
        if (x >= (1 << (w-1))) x -= (1 << w);
        if (y >= (1 << (w-1))) y -= (1 << w);
`endif
        return (x * y) & ((1 << (2*w)) - 1);
    endfunction

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] pick();
        int r = $urandom_range(0, 7);
        return r == 0 ? '0 : r == 1 ? '1 : r == 2 ? {1'b1, {(W-1){1'b0}}} :
               r == 3 ? {1'b0, {(W-1){1'b1}}} : W'($urandom);
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got p=%0h, no product outstanding", p);
            end else check("product", int'(p), q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (out_valid4) begin
            if (got4 == 0) begin
                first_out4 = cyc;
                check("exh_latency", cyc - first_acc4, 4);
            end
            last_out4 = cyc;
            got4++;
            if (q4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL exh_unexpected: got p=%0h, no product outstanding", p4);
            end else check("exh_product", int'(p4), q4.pop_front());
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) q.push_back(model(int'(x), int'(y), W));
        else check("send_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int seen;
        #2;
        check("reset_ov", int'(out_valid), 0);
        check("reset_p", int'(p), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        send(8'hFF, 8'hFF);
        repeat (S) @(negedge clk);
        check("pre_latency_ov", int'(out_valid), 0);
        @(negedge clk);
        check("latency_ov", int'(out_valid), 1);
        check("ff_p", int'(p), model(255, 255, W));
        @(negedge clk);
        check("one_cycle_ov", int'(out_valid), 0);
        @(posedge clk);
        #1;

        send(8'h80, 8'h80);
        send(8'hFF, 8'h7F);
        send(8'h80, 8'h7F);
        send(8'h00, 8'hFF);
        send(8'h7F, 8'h7F);
        drain();

        out_ready = 1'b0;
        send(3, 5);
        send(7, 9);
        send(15, 15);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        check("stall_ov", int'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_p", int'(p), model(3, 5, W));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        send(2, 2);
        @(posedge clk);
        #1;
        send(6, 7);
        repeat (S-1) @(negedge clk);
        check("bubble_ov0", int'(out_valid), 1);
        check("bubble_p0", int'(p), model(2, 2, W));
        @(negedge clk);
        check("bubble_ov1", int'(out_valid), 0);
        @(negedge clk);
        check("bubble_ov2", int'(out_valid), 1);
        check("bubble_p2", int'(p), model(6, 7, W));
        @(posedge clk);
        #1;
        drain();

        repeat (400) begin
            out_ready = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 2) != 0;
            a = pick();
            b = pick();
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(model(int'(a), int'(b), W));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        repeat (S+1) send(W'($urandom), W'($urandom));
        reset_n = 1'b0;
        q.delete();
        #1;
        check("midreset_ov", int'(out_valid), 0);
        check("midreset_p", int'(p), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        repeat (2*S+2) begin
            @(negedge clk);
            seen |= int'(out_valid);
        end
        check("stale_after_reset", seen, 0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 256; n++) begin
            a4 = 4'(n >> 4);
            b4 = 4'(n);
            in_valid4 = 1'b1;
            @(negedge clk);
            if (in_ready4) begin
                if (first_acc4 < 0) first_acc4 = cyc + 1;
                q4.push_back(model(int'(a4), int'(b4), 4));
            end
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        repeat (10) @(negedge clk);
        check("exh_count", got4, 256);
        check("exh_span", last_out4 - first_out4, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
